// File: rtl/cap_sensor_scanner.sv
// cap_sensor_scanner: times capacitive pad charge-up, debounces touches and queues per-pad hit events
module cap_sensor_scanner #(
   parameter int NUM_SENSORS      = 9,
   parameter int CNT_W            = 16,
   parameter int DISCHARGE_CYCLES = 256,
   parameter int CHARGE_TIMEOUT   = 4095,
   parameter int THRESHOLD        = 200,
   parameter int DEBOUNCE         = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
   output logic                   capacitive_sensors_out,
   input  logic                   enable,
   output logic [NUM_SENSORS-1:0] touch_state,
   output logic                   scan_done,
   output logic                   hit_valid,
   output logic [3:0]             hit_id,
   input  logic                   hit_ack
);
   typedef enum logic [1:0] {IDLE, DISCHARGE, CHARGE, EVAL} state_t;
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(CHARGE_TIMEOUT);
   localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);
   localparam logic [CNT_W-1:0] DIS_END = CNT_W'(DISCHARGE_CYCLES - 1);
   localparam logic [2:0]       DB      = 3'(DEBOUNCE);
   state_t state, state_nx;
   logic [NUM_SENSORS-1:0] sync_a, sync_in, done, touch_nx, pending, pending_nx;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] count [NUM_SENSORS];
   logic [2:0] agree [NUM_SENSORS];
   logic [2:0] agree_nx [NUM_SENSORS];
   logic [3:0] id_nx;
   assign capacitive_sensors_out = (state == CHARGE);
   // two-flop synchronizer for the asynchronous pad inputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_a  <= '0;
         sync_in <= '0;
      end else begin
         sync_a  <= capacitive_sensors_in;
         sync_in <= sync_a;
      end
   end
   // scan sequencing: discharge for a fixed time, then charge until every pad has risen or the timeout hits
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = enable ? DISCHARGE : IDLE;
         DISCHARGE: state_nx = (counter == DIS_END) ? CHARGE : DISCHARGE;
         CHARGE:    state_nx = (&(done | sync_in) || counter == TMO) ? EVAL : CHARGE;
         default:   state_nx = enable ? DISCHARGE : IDLE;
      endcase
   end
   // state register, shared phase counter (restarts on every state change) and per-pad rise-time capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         counter <= '0;
         done    <= '0;
         for (int i = 0; i < NUM_SENSORS; i++) count[i] <= '0;
      end else begin
         state   <= state_nx;
         counter <= (state != state_nx) ? '0 : (counter == TMO) ? counter : counter + CNT_W'(1);
         if (state_nx == DISCHARGE && state != DISCHARGE) done <= '0;
         else if (state == CHARGE) done <= done | sync_in;
         for (int i = 0; i < NUM_SENSORS; i++)
            if (state == CHARGE && !done[i] && (sync_in[i] || counter == TMO)) count[i] <= counter;
      end
   end
   // debounce: a pad flips only after DEBOUNCE consecutive scans disagreeing with its current state
   always_comb begin
      touch_nx = touch_state;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         agree_nx[i] = agree[i];
         if (state == EVAL) begin
            if ((count[i] >= THR) == touch_state[i]) agree_nx[i] = '0;
            else if (agree[i] + 3'd1 == DB) begin
               agree_nx[i] = '0;
               touch_nx[i] = ~touch_state[i];
            end else agree_nx[i] = agree[i] + 3'd1;
         end
      end
   end
   // hit queue: ack clears the presented bit, new touches set theirs (set wins), lowest index is presented
   always_comb begin
      pending_nx = pending;
      if (hit_ack && hit_valid) pending_nx[hit_id] = 1'b0;
      pending_nx = pending_nx | (touch_nx & ~touch_state);
      id_nx = '0;
      for (int i = NUM_SENSORS - 1; i >= 0; i--) if (pending_nx[i]) id_nx = 4'(i);
   end
   // debounced state, pending hits and the registered handshake outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         touch_state <= '0;
         pending     <= '0;
         hit_valid   <= 1'b0;
         hit_id      <= '0;
         scan_done   <= 1'b0;
         for (int i = 0; i < NUM_SENSORS; i++) agree[i] <= '0;
      end else begin
         touch_state <= touch_nx;
         pending     <= pending_nx;
         hit_valid   <= |pending_nx;
         hit_id      <= id_nx;
         scan_done   <= (state == EVAL);
         for (int i = 0; i < NUM_SENSORS; i++) agree[i] <= agree_nx[i];
      end
   end
endmodule

// File: tb/tb_cap_sensor_scanner.sv
// tb_cap_sensor_scanner: emulates pad RC rise times and checks scans against a scan-level behavioural model
module tb_cap_sensor_scanner;
   localparam int N = 9, TMO = 4095, THR = 200, DB = 3, DIS = 256, NEVER = 1000000;
   logic clock = 0, reset = 0, enable = 0, hit_ack = 0;
   logic drive, scan_done, hit_valid;
   logic [N-1:0] pads = '0, touch_state;
   logic [3:0] hit_id;
   int dly [N];
   int n_cmp = 0, n_err = 0, cyc = 0, k = 0, last_done = -1, period = -1, m_max = 0;
   logic [N-1:0] m_touch = '0, m_pend = '0;
   int m_run [N];

   cap_sensor_scanner dut (
      .clock(clock), .reset(reset), .capacitive_sensors_in(pads), .capacitive_sensors_out(drive),
      .enable(enable), .touch_state(touch_state), .scan_done(scan_done), .hit_valid(hit_valid),
      .hit_id(hit_id), .hit_ack(hit_ack));

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   // pad emulation: pad i reads high dly[i] cycles after the drive rises, low while discharged
   initial forever begin
      @(posedge clock); #1;
      if (!drive) begin
         k = 0;
         pads = '0;
      end else begin
         for (int i = 0; i < N; i++) pads[i] = (k >= dly[i]);
         k++;
      end
   end

   function automatic int lowest(logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic set_all(input int v);
      for (int i = 0; i < N; i++) dly[i] = v;
   endtask

   task automatic model_reset();
      m_touch = '0;
      m_pend = '0;
      last_done = -1;
      for (int i = 0; i < N; i++) m_run[i] = 0;
   endtask

   // one scan seen from the pad's side: rise count = delay + 2 sync cycles, capped at the timeout
   task automatic model_scan();
      m_max = 0;
      for (int i = 0; i < N; i++) begin
         int c;
         c = (dly[i] + 2 > TMO) ? TMO : dly[i] + 2;
         if (c > m_max) m_max = c;
         if ((c >= THR) != m_touch[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_touch[i] = !m_touch[i];
               m_run[i] = 0;
               if (m_touch[i]) m_pend[i] = 1'b1;
            end
         end else m_run[i] = 0;
      end
   endtask

   task automatic run_scan(input bit ack_eval);
      bit prev = 0, fired = 0, got = 0;
      int n = 0;
      while (n < 6000 && !got) begin
         @(negedge clock);
         n++;
         if (ack_eval && prev && !drive && !fired) begin
            hit_ack = 1;
            fired = 1;
            if (|m_pend) m_pend[lowest(m_pend)] = 1'b0;
         end
         got = scan_done;
         prev = drive;
      end
      hit_ack = 0;
      if (!got) begin
         n_cmp++; n_err++;
         $display("FAIL scan_wait: no scan_done within %0d cycles", n);
      end
      period = (last_done >= 0) ? cyc - last_done : -1;
      last_done = cyc;
      model_scan();
   endtask

   task automatic do_ack();
      @(negedge clock);
      hit_ack = 1;
      if (|m_pend) m_pend[lowest(m_pend)] = 1'b0;
      @(negedge clock);
      hit_ack = 0;
   endtask

   task automatic settle();
      set_all(50);
      repeat (3) run_scan(0);
      while (|m_pend) do_ack();
   endtask

   task automatic test_reset();
      int sd = 0, dr = 0;
      repeat (3) @(negedge clock);
      n_cmp++; if ({drive, scan_done, hit_valid, hit_id, touch_state} !== '0) begin n_err++; $display("FAIL reset_outputs: got %b want 0", {drive, scan_done, hit_valid, hit_id, touch_state}); end
      #2 reset = 1;
      repeat (1000) begin
         @(negedge clock);
         sd += int'(scan_done);
         dr += int'(drive);
      end
      n_cmp++; if (sd != 0 || dr != 0) begin n_err++; $display("FAIL idle_quiet: scan_done=%0d drive=%0d cycles, want 0", sd, dr); end
   endtask

   task automatic test_untouched();
      set_all(50);
      enable = 1;
      for (int s = 0; s < 3; s++) begin
         run_scan(0);
         if (s > 0) begin
            n_cmp++; if (period != DIS + m_max + 2 || period != 310) begin n_err++; $display("FAIL untouched_period: got %0d want %0d", period, DIS + m_max + 2); end
         end
         n_cmp++; if (touch_state !== m_touch || hit_valid !== 1'b0) begin n_err++; $display("FAIL untouched_state: touch=%b valid=%b want touch=%b valid=0", touch_state, hit_valid, m_touch); end
      end
   endtask

   task automatic test_debounce();
      set_all(50);
      dly[4] = 300;
      for (int s = 0; s < 3; s++) begin
         run_scan(0);
         n_cmp++; if (touch_state[4] !== (s == 2) || touch_state !== m_touch) begin n_err++; $display("FAIL debounce_scan%0d: touch=%b want %b", s, touch_state, m_touch); end
      end
      n_cmp++; if (hit_valid !== 1'b1 || hit_id !== 4'd4) begin n_err++; $display("FAIL debounce_hit: valid=%b id=%0d want 1/4", hit_valid, hit_id); end
      do_ack();
      n_cmp++; if (hit_valid !== 1'b0) begin n_err++; $display("FAIL debounce_ack: valid=%b want 0", hit_valid); end
      settle();
      n_cmp++; if (touch_state !== '0 || hit_valid !== 1'b0) begin n_err++; $display("FAIL release_no_hit: touch=%b valid=%b want 0/0", touch_state, hit_valid); end
   endtask

   task automatic test_priority();
      set_all(50);
      dly[7] = 400;
      dly[2] = 400;
      repeat (3) run_scan(0);
      n_cmp++; if (hit_valid !== 1'b1 || hit_id !== 4'd2) begin n_err++; $display("FAIL prio_first: valid=%b id=%0d want 1/2", hit_valid, hit_id); end
      do_ack();
      n_cmp++; if (hit_valid !== 1'b1 || hit_id !== 4'd7) begin n_err++; $display("FAIL prio_second: valid=%b id=%0d want 1/7", hit_valid, hit_id); end
      do_ack();
      n_cmp++; if (hit_valid !== 1'b0) begin n_err++; $display("FAIL prio_empty: valid=%b want 0", hit_valid); end
      settle();
   endtask

   task automatic test_ack_collision();
      set_all(50);
      dly[2] = 400;
      repeat (3) run_scan(0);
      dly[2] = 50;
      repeat (3) run_scan(0);
      n_cmp++; if (touch_state[2] !== 1'b0 || hit_valid !== 1'b1 || hit_id !== 4'd2) begin n_err++; $display("FAIL collide_pre: touch2=%b valid=%b id=%0d want 0/1/2", touch_state[2], hit_valid, hit_id); end
      dly[2] = 400;
      repeat (2) run_scan(0);
      run_scan(1);
      n_cmp++; if (touch_state[2] !== 1'b1 || hit_valid !== |m_pend || hit_id !== 4'(lowest(m_pend)) || hit_valid !== 1'b1) begin n_err++; $display("FAIL collide_set_wins: touch2=%b valid=%b id=%0d want 1/1/2", touch_state[2], hit_valid, hit_id); end
      do_ack();
      n_cmp++; if (hit_valid !== 1'b0) begin n_err++; $display("FAIL collide_single: valid=%b want 0", hit_valid); end
      settle();
   endtask

   task automatic test_threshold();
      set_all(50);
      dly[5] = THR - 2;
      dly[6] = THR - 3;
      repeat (3) run_scan(0);
      n_cmp++; if (touch_state[5] !== 1'b1 || touch_state[6] !== 1'b0 || hit_id !== 4'd5) begin n_err++; $display("FAIL threshold_edge: touch=%b id=%0d want pad5 only", touch_state, hit_id); end
      settle();
   endtask

   task automatic test_timeout();
      set_all(50);
      dly[0] = NEVER;
      for (int s = 0; s < 3; s++) begin
         run_scan(0);
         n_cmp++; if (period != DIS + TMO + 2) begin n_err++; $display("FAIL timeout_period: got %0d want %0d", period, DIS + TMO + 2); end
      end
      n_cmp++; if (touch_state[0] !== 1'b1 || hit_valid !== 1'b1 || hit_id !== 4'd0) begin n_err++; $display("FAIL timeout_touch: touch=%b valid=%b id=%0d want pad0", touch_state, hit_valid, hit_id); end
      do_ack();
      dly[0] = 48;
      repeat (2) run_scan(0);
      dly[0] = NEVER;
      run_scan(0);
      n_cmp++; if (touch_state[0] !== 1'b1 || hit_valid !== 1'b0 || touch_state !== m_touch) begin n_err++; $display("FAIL glitch_hold: touch=%b valid=%b want %b/0", touch_state, hit_valid, m_touch); end
      settle();
   endtask

   task automatic test_random();
      for (int s = 0; s < 12; s++) begin
         for (int i = 0; i < N; i++) dly[i] = ($urandom_range(0, 9) < 6) ? int'($urandom_range(10, 150)) : int'($urandom_range(250, 700));
         if ($urandom_range(0, 1) == 1) do_ack();
         run_scan(0);
         n_cmp++; if (touch_state !== m_touch || hit_valid !== |m_pend || hit_id !== 4'(lowest(m_pend))) begin n_err++; $display("FAIL random_scan%0d: touch=%b valid=%b id=%0d want %b/%b/%0d", s, touch_state, hit_valid, hit_id, m_touch, |m_pend, lowest(m_pend)); end
         n_cmp++; if (period != DIS + m_max + 2) begin n_err++; $display("FAIL random_period%0d: got %0d want %0d", s, period, DIS + m_max + 2); end
      end
      settle();
   endtask

   task automatic test_async_reset();
      int n = 0;
      set_all(50);
      dly[3] = 400;
      repeat (3) run_scan(0);
      while (!drive && n < 2000) begin
         @(negedge clock);
         n++;
      end
      repeat (20) @(negedge clock);
      #2 reset = 0;
      #1;
      n_cmp++; if ({drive, hit_valid, touch_state, hit_id, scan_done} !== '0) begin n_err++; $display("FAIL async_reset: drive=%b valid=%b touch=%b id=%0d want all 0", drive, hit_valid, touch_state, hit_id); end
      repeat (3) @(negedge clock);
      #2 reset = 1;
      model_reset();
      n = 0;
      while (!drive && n < 2000) begin
         @(negedge clock);
         n++;
      end
      n_cmp++; if (n != DIS + 1) begin n_err++; $display("FAIL restart_discharge: charge after %0d cycles, want %0d", n, DIS + 1); end
      run_scan(0);
      n_cmp++; if (touch_state !== m_touch || hit_valid !== 1'b0) begin n_err++; $display("FAIL restart_scan: touch=%b valid=%b want %b/0", touch_state, hit_valid, m_touch); end
   endtask

   initial begin
      set_all(50);
      model_reset();
      test_reset();
      test_untouched();
      test_debounce();
      test_priority();
      test_ack_collision();
      test_threshold();
      test_timeout();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cap_sensor_scanner.md
Name: cap_sensor_scanner

Overview:
- Input-side counterpart to the LED command path of the whack-a-mole processor: repeatedly charges the 9 capacitive pads and times each pad's rise.
- Converts each pad's rise time to a touched/untouched decision, debounces it, and queues per-pad hit events.
- The processor consumes hits through a valid/ack handshake.
- Sits between the board pins (capacitive_sensors_out / capacitive_sensors_in) and the processor's memory-mapped I/O.

Parameters:
- NUM_SENSORS, 9, number of pads; hit_id width is 4.
- CNT_W, 16, charge-counter width.
- DISCHARGE_CYCLES, 256, cycles the drive pin is held low before each charge.
- CHARGE_TIMEOUT, 4095, maximum charge count; must be < 2^CNT_W.
- THRESHOLD, 200, rise count at or above which a pad is raw-touched.
- DEBOUNCE, 3, consecutive agreeing scans (1..7) required to change touch_state.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- capacitive_sensors_in  in  NUM_SENSORS  raw pad inputs, asynchronous.
- capacitive_sensors_out  out  1  common charge/discharge drive.
- enable  in  1  run scans while high.
- touch_state  out  NUM_SENSORS  debounced touched flags.
- scan_done  out  1  one-cycle pulse at the end of each scan's EVAL.
- hit_valid  out  1  at least one pending hit.
- hit_id  out  4  index of the lowest pending hit.
- hit_ack  in  1  consumer accepts hit_id.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM=IDLE; capacitive_sensors_out=0, touch_state=0, scan_done=0, hit_valid=0, hit_id=0.
  - All counters, debounce counters, pending bits and synchronizers cleared.
- Inputs pass through a 2-flop synchronizer. Every timing statement below uses the synchronized value.
- FSM:
  - IDLE: drive=0. Goes to DISCHARGE when enable=1.
  - DISCHARGE: drive=0 for exactly DISCHARGE_CYCLES cycles, then CHARGE. Counter and per-pad done flags clear on entry.
  - CHARGE: drive=1; counter starts at 0 on the first CHARGE cycle and increments by 1 each cycle.
    - Pad i not yet done with sync_in[i]=1 latches count[i]=counter and sets done[i].
    - Exit to EVAL when all pads are done, or when counter==CHARGE_TIMEOUT. On timeout, undone pads latch count=CHARGE_TIMEOUT.
  - EVAL: 1 cycle, drive=0. raw[i] = (count[i] >= THRESHOLD), then update debounce and pulse scan_done.
    - Next state is DISCHARGE if enable=1, else IDLE.
- enable deasserting mid-scan does not abort; the scan completes through EVAL.
- Debounce per pad:
  - 3-bit agree counter. If raw[i] != touch_state[i], increment; on reaching DEBOUNCE, toggle touch_state[i] and clear the counter.
  - If raw[i] == touch_state[i], clear the counter.
  - touch_state changes only in EVAL.
- Hit queue:
  - A 0->1 transition of touch_state[i] sets pending[i]. Falling transitions generate nothing.
  - hit_valid = |pending; hit_id = index of the lowest set pending bit (registered, same cycle as pending).
  - hit_ack while hit_valid clears pending[hit_id] at the next edge. hit_ack with hit_valid=0 is ignored.
  - hit_id is stable while hit_valid=1 and hit_ack=0, except when a lower-index bit becomes pending; the lower index is then presented immediately.
  - A set and a clear of the same bit in the same cycle leaves the bit set.
  - A re-touch of an already pending pad is not double-counted.
- Arithmetic:
  - The counter saturates at CHARGE_TIMEOUT and never wraps.
  - Comparisons are unsigned.
  - Equality with THRESHOLD counts as touched.

Test Plan:
- Reset/idle: reset low, then released with enable=0 → all outputs 0, drive stays 0, no scan_done for 1000 cycles.
- Untouched pads: enable=1; bench raises all inputs 50 cycles after drive rises.
  - Expected: scan_done every ~256+53+1 cycles, count≈52 (<200), touch_state stays 0, hit_valid=0.
- Touch with debounce: pad 4 rises at 300 cycles while the others rise at 50.
  - Expected: touch_state[4]=1 exactly at the 3rd scan's EVAL, hit_valid=1, hit_id=4.
  - After hit_ack: hit_valid=0 the next cycle.
- Priority and simultaneous ack: pads 7 and 2 touched in the same scans.
  - Expected: hit_id=2 first; after ack, hit_id=7; after second ack, hit_valid=0.
  - Separately, pad 2 acked in the same cycle its new rising event sets → pending[2] remains 1.
- Timeout: pad 0 input held low forever.
  - Expected: each CHARGE lasts 4096 cycles, count[0]=4095, touch_state[0]=1 after 3 scans.
  - Pad 0 glitching to 50 for 2 scans then back to timeout → no release, no new hit.
- Async reset mid-CHARGE, with pending hits present: drive=0, hit_valid=0 and touch_state=0 immediately, before any clock edge; the scan restarts from DISCHARGE after release.
